// File: rtl/matrix_pkg.sv
// Shared types and constants for the block-matrix command sequencer.
package matrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MULT  = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Upper two bits of the 5-bit command word select the operation class
    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_STORE = 2'b01;

    localparam int LOADS_PER_TILE  = 8;
    localparam int STORES_PER_TILE = 4;

    // Tile index width covers the full 1..255 tile range
    localparam int TILE_W = 8;

endpackage

// File: rtl/seq_addr_gen.sv
// Address generation for the sequencer: base addresses are captured on an
// accepted start, and the command address is formed from the captured base,
// the current tile and the block index within the tile.
module seq_addr_gen
    import matrix_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  state_t            state,
    input  logic [TILE_W-1:0] tile,
    input  logic [2:0]        idx,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] tile_ext;
    logic [ADDR_W-1:0] idx_ext;

    assign tile_ext = ADDR_W'(tile);
    assign idx_ext  = ADDR_W'(idx);

    // Capture base addresses only when a run is accepted, so later base changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= '0;
            dst_q <= '0;
        end else if (base_load) begin
            src_q <= src_base;
            dst_q <= dst_base;
        end
    end

    // Address follows registered state/tile/idx, so it holds steady under backpressure
    always_comb begin
        addr = '0;
        case (state)
            S_LOAD:  addr = src_q + (tile_ext << 3) + idx_ext;
            S_STORE: addr = dst_q + (tile_ext << 2) + idx_ext;
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/matrix_sequencer.sv
// Command sequencer for the block-matrix datapath decoder.
// Per tile: 8 load commands, one multiply, 4 store commands.
// Optional build macro SEQ_PERF_CNT_EN adds the stall_cycles counter output.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | waiting for start
//   S_LOAD  | issuing load commands A..H for the current tile
//   S_MULT  | waiting for mult_done, timeout down-counter runs
//   S_STORE | issuing store commands J..M for the current tile
//   S_NEXT  | advance to next tile or finish
//   S_DONE  | one-cycle done pulse, then back to idle
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int NUM_TILES    = 4,
    parameter int ADDR_W       = 8,
    parameter int MULT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [4:0]        command,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mult_start,
    input  logic              mult_done,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int WAIT_W = $clog2(MULT_TIMEOUT) + 1;

    state_t              state;
    logic [TILE_W-1:0]   tile;
    logic [2:0]          idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept_start;

    assign accept_start = (state == S_IDLE) && start;

    seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .base_load (accept_start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .state     (state),
        .tile      (tile),
        .idx       (idx),
        .addr      (mem_addr)
    );

    // Main sequencing FSM with registered command/handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tile       <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            cmd_valid  <= 1'b0;
            command    <= '0;
            mult_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        tile      <= '0;
                        idx       <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        cmd_valid <= 1'b1;
                        command   <= {CMD_LOAD, 3'd0};
                    end
                end
                S_LOAD: begin
                    if (cmd_ready) begin
                        if (idx == 3'(LOADS_PER_TILE - 1)) begin
                            state      <= S_MULT;
                            idx        <= '0;
                            cmd_valid  <= 1'b0;
                            command    <= '0;
                            mult_start <= 1'b1;
                            wait_cnt   <= WAIT_W'(MULT_TIMEOUT - 1);
                        end else begin
                            idx     <= idx + 3'd1;
                            command <= {CMD_LOAD, idx + 3'd1};
                        end
                    end
                end
                S_MULT: begin
                    // mult_done takes priority over a timeout expiring in the same cycle
                    if (mult_done) begin
                        state     <= S_STORE;
                        idx       <= '0;
                        cmd_valid <= 1'b1;
                        command   <= {CMD_STORE, 3'd0};
                    end else if (wait_cnt == '0) begin
                        state <= S_DONE;
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_STORE: begin
                    if (cmd_ready) begin
                        if (idx == 3'(STORES_PER_TILE - 1)) begin
                            state     <= S_NEXT;
                            idx       <= '0;
                            cmd_valid <= 1'b0;
                            command   <= '0;
                        end else begin
                            idx     <= idx + 3'd1;
                            command <= {CMD_STORE, 1'b0, idx[1:0] + 2'd1};
                        end
                    end
                end
                S_NEXT: begin
                    if (tile == TILE_W'(NUM_TILES - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state     <= S_LOAD;
                        tile      <= tile + 1'b1;
                        idx       <= '0;
                        cmd_valid <= 1'b1;
                        command   <= {CMD_LOAD, 3'd0};
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Saturating count of cycles where a command is offered but not taken
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (accept_start) begin
            stall_cycles <= '0;
        end else if (cmd_valid && !cmd_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/matrix_sequencer.md
Name: matrix_sequencer

Overview:
- Upstream command generator for the block-matrix datapath decoder (the fsm block).
- Walks NUM_TILES tiles. For each tile it issues 8 load commands (blocks A..H), waits for the multiply unit, then issues 4 store commands (results J..M).
- Produces the 5-bit command word consumed by fsm, plus the memory address for each command.

Parameters:
- NUM_TILES, 4, tiles processed per start; legal range 1..255.
- ADDR_W, 8, width of memory address output.
- MULT_TIMEOUT, 64, maximum cycles to wait for mult_done before flagging an error.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- src_base  input  ADDR_W  base address of operand blocks; sampled on accepted start.
- dst_base  input  ADDR_W  base address of result blocks; sampled on accepted start.
- cmd_valid  output  1  command and mem_addr are valid.
- cmd_ready  input  1  downstream accepts the command this cycle.
- command  output  5  command word to fsm.
- mem_addr  output  ADDR_W  address paired with command.
- mult_start  output  1  one-cycle pulse to the multiply unit.
- mult_done  input  1  multiply unit finished current tile.
- busy  output  1  high from accepted start until DONE is entered.
- done  output  1  one-cycle pulse at end of run.
- error  output  1  sticky; set on multiply timeout, cleared by reset or next accepted start.

Behaviour:
- Reset values: cmd_valid=0, command=0, mem_addr=0, mult_start=0, busy=0, done=0, error=0. State goes to IDLE and all counters go to 0.
- States: IDLE, LOAD, MULT, STORE, NEXT, DONE.
- IDLE:
  - start=1 latches src_base/dst_base, clears error, sets tile=0 and idx=0, moves to LOAD next cycle.
  - start while not IDLE is ignored.
- LOAD:
  - cmd_valid=1, command={2'b00, idx[2:0]} (values 0..7), mem_addr = src_base + tile*8 + idx, mod 2^ADDR_W.
  - Handshake: command and mem_addr hold stable while cmd_valid=1 and cmd_ready=0.
  - On cmd_valid & cmd_ready the command retires and idx increments.
  - On retirement of idx=7: idx->0, go to MULT, and assert mult_start for exactly one cycle on MULT entry.
- MULT:
  - cmd_valid=0; a wait counter runs.
  - mult_done=1 -> STORE next cycle.
  - mult_done is ignored in all other states.
  - If the counter reaches MULT_TIMEOUT without mult_done: set error, go to DONE, skip the remaining tiles.
- STORE:
  - cmd_valid=1, command={2'b01, idx[1:0]} (values 8..11), mem_addr = dst_base + tile*4 + idx.
  - Same handshake as LOAD.
  - On retirement of idx=3: go to NEXT.
- NEXT (one cycle, cmd_valid=0):
  - tile == NUM_TILES-1 -> DONE.
  - Otherwise tile increments, idx=0, go to LOAD.
- DONE: done=1 for one cycle, busy=0 from this cycle, go to IDLE.
- Latency (cmd_ready tied high, mult_done on the first MULT cycle): per tile 8 LOAD + 1 MULT + 4 STORE + 1 NEXT = 14 cycles. Run = 1 + 14*NUM_TILES + 1 cycles from start to done.
- cmd_ready while cmd_valid=0 has no effect.
- Simultaneous mult_done and timeout expiry in the same cycle: mult_done wins, no error.
- Reset mid-run: everything returns to reset values in the next cycle; no done pulse is produced.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- With it defined:
  - Added output stall_cycles, 16 bits.
  - Counts cycles with cmd_valid=1 and cmd_ready=0 during a run.
  - Cleared on accepted start; holds its value after done; saturates at 16'hFFFF.
- Without it: the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared package matrix_pkg holds:
  - state enum;
  - command field constants: CMD_LOAD=2'b00, CMD_STORE=2'b01;
  - LOADS_PER_TILE=8, STORES_PER_TILE=4.
- One natural sub-module, seq_addr_gen: combinational-plus-registered address computation from base, tile and idx.

Test Plan:
- Ready always high: NUM_TILES=1, src_base=8'h10, dst_base=8'h80, mult_done on the first MULT cycle.
  -> commands 0..7 at 0x10..0x17, one mult_start pulse, commands 8..11 at 0x80..0x83, done 15 cycles after start.
- Backpressure: cmd_ready low 3 cycles on LOAD idx=2.
  -> command=2 and mem_addr=0x12 held stable for all 3 cycles; no skip or duplicate; stall_cycles=3 when SEQ_PERF_CNT_EN is defined.
- Multi-tile: NUM_TILES=2.
  -> second tile loads at 0x18..0x1F and stores at 0x84..0x87; exactly one done pulse.
- Timeout: mult_done never asserted.
  -> error=1 after MULT_TIMEOUT cycles, done pulses, no STORE commands issued.
- Reset mid-STORE at idx=1.
  -> all outputs 0 next cycle, state IDLE; a later start runs cleanly with error=0.
- Start asserted while busy.
  -> ignored; base addresses unchanged; only one done pulse.
